imem_loader: RTL and testbench

//  Boot-time writer for the instruction memory that the CPU fetches from (PC, byte-addressed, +4/word).

---
 rtl/imem_loader.sv | 182 ++++++++++++++++++
 tb/tb_imem_loader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot loader for the instruction memory: parses a count/payload/checksum byte stream,
// writes each word to the memory port and releases the CPU reset only after a good image.
module imem_loader #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       words_loaded
);

    typedef enum logic [2:0] {
        StCntLo,
        StCntHi,
        StData,
        StCsum,
        StDone,
        StErr
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [1:0]        lane_q, lane_d;
    logic [23:0]       buf_q, buf_d;
    logic [7:0]        csum_q, csum_d;
    logic [15:0]       words_q, words_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              cpu_rst_q, cpu_rst_d;

    logic              accept;
    logic [15:0]       cnt_full;

    assign rx_ready = (state_q != StDone) && (state_q != StErr);
    assign accept   = rx_valid && rx_ready;
    // Count as it will be once the high byte lands; lets CNT_HI decide in the same cycle.
    assign cnt_full = {rx_data, cnt_q[7:0]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lane_d    = lane_q;
        buf_d     = buf_q;
        csum_d    = csum_q;
        words_d   = words_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        cpu_rst_d = cpu_rst_q;

        unique case (state_q)
            StCntLo: begin
                if (accept) begin
                    cnt_d[7:0] = rx_data;
                    busy_d     = 1'b1;
                    state_d    = StCntHi;
                end
            end
            StCntHi: begin
                if (accept) begin
                    cnt_d[15:8] = rx_data;
                    if (cnt_full == 16'd0) begin
                        state_d = StCsum;
                    end else if (32'(cnt_full) > MAX_WORDS) begin
                        state_d = StErr;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    csum_d = csum_q ^ rx_data;
                    lane_d = lane_q + 2'd1;
                    unique case (lane_q)
                        2'd0: buf_d[7:0]   = rx_data;
                        2'd1: buf_d[15:8]  = rx_data;
                        2'd2: buf_d[23:16] = rx_data;
                        default: begin
                            we_d    = 1'b1;
                            addr_d  = ADDR_W'({words_q, 2'b00});
                            wdata_d = {rx_data, buf_q};
                            words_d = words_q + 16'd1;
                            if (words_q == cnt_q - 16'd1) begin
                                state_d = StCsum;
                            end
                        end
                    endcase
                end
            end
            StCsum: begin
                if (accept) begin
                    busy_d = 1'b0;
                    if (rx_data == csum_q) begin
                        state_d   = StDone;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end
                end
            end
            StDone, StErr: begin
                if (start) begin
                    state_d   = StCntLo;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    words_d   = 16'd0;
                    csum_d    = 8'd0;
                    lane_d    = 2'd0;
                    cpu_rst_d = 1'b1;
                end
            end
            default: begin
                state_d = StCntLo;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StCntLo;
            cnt_q     <= 16'd0;
            lane_q    <= 2'd0;
            buf_q     <= 24'd0;
            csum_q    <= 8'd0;
            words_q   <= 16'd0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cpu_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lane_q    <= lane_d;
            buf_q     <= buf_d;
            csum_q    <= csum_d;
            words_q   <= words_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cpu_rst_q <= cpu_rst_d;
        end
    end

    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign cpu_rst      = cpu_rst_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued at stimulus time, a monitor
// checks every mem_we pulse; status flags are checked after each frame.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        start;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] words_loaded;

    int          total;
    int          bad;
    logic [63:0] sb[$];
    logic        prev_we;
    logic [7:0]  frame[$];

    imem_loader #(
        .ADDR_W   (32),
        .MAX_WORDS(256)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .start       (start),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .cpu_rst     (cpu_rst),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write must match the oldest expected write and last exactly one cycle.
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            chk("we_single_cycle", {31'd0, prev_we}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_write_addr", mem_addr, 32'hFFFF_FFFF);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                chk("write_addr", mem_addr, e[63:32]);
                chk("write_data", mem_wdata, e[31:0]);
            end
        end
        prev_we = mem_we;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Drive at negedge; returns on the negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int tries;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        tries    = 0;
        while (!rx_ready && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        if (!rx_ready) chk("rx_ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input int maxgap);
        foreach (frame[i]) send_byte(frame[i], (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_case1();
        sb.push_back({32'h0000_0000, 32'hE3A0_1005});
        sb.push_back({32'h0000_0004, 32'h0000_0000});
    endtask

    task automatic chk_status(input string tag, input logic e_done, input logic e_err,
                              input logic e_cpu_rst, input logic [15:0] e_words);
        chk({tag, "_done"}, {31'd0, done}, {31'd0, e_done});
        chk({tag, "_err"}, {31'd0, err}, {31'd0, e_err});
        chk({tag, "_cpu_rst"}, {31'd0, cpu_rst}, {31'd0, e_cpu_rst});
        chk({tag, "_words"}, {16'd0, words_loaded}, {16'd0, e_words});
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        prev_we  = 1'b0;
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        start    = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_words", {16'd0, words_loaded}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);

        // Case 1: two-word image, good checksum
        push_case1();
        frame = '{8'h02, 8'h00, 8'h05, 8'h10, 8'hA0, 8'hE3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h56};
        send_byte(frame[0], 0);
        chk("c1_busy_after_first", {31'd0, busy}, 32'd1);
        frame.delete(0);
        send_frame(0);
        chk_status("c1", 1'b1, 1'b0, 1'b0, 16'd2);
        chk("c1_rx_ready", {31'd0, rx_ready}, 32'd0);

        // Case 2: same frame, bad checksum
        pulse_start();
        chk("c2_cpu_rst_reassert", {31'd0, cpu_rst}, 32'd1);
        chk("c2_done_cleared", {31'd0, done}, 32'd0);
        chk("c2_words_cleared", {16'd0, words_loaded}, 32'd0);
        push_case1();
        frame = '{8'h02, 8'h00, 8'h05, 8'h10, 8'hA0, 8'hE3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h57};
        send_frame(0);
        chk_status("c2", 1'b0, 1'b1, 1'b1, 16'd2);
        chk("c2_rx_ready", {31'd0, rx_ready}, 32'd0);
        // start is honoured in ERR; rx ignored while ERR so no stray writes happen here
        repeat (3) @(negedge clk);

        // Case 3a: empty image
        pulse_start();
        chk("c3a_err_cleared", {31'd0, err}, 32'd0);
        frame = '{8'h00, 8'h00, 8'h00};
        send_frame(0);
        chk_status("c3a", 1'b1, 1'b0, 1'b0, 16'd0);

        // Case 3b: count 257 too large
        pulse_start();
        frame = '{8'h01, 8'h01};
        send_frame(0);
        chk_status("c3b", 1'b0, 1'b1, 1'b1, 16'd0);
        chk("c3b_rx_ready", {31'd0, rx_ready}, 32'd0);
        repeat (4) @(negedge clk);

        // Case 4: case 1 with random gaps
        pulse_start();
        push_case1();
        frame = '{8'h02, 8'h00, 8'h05, 8'h10, 8'hA0, 8'hE3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h56};
        send_frame(5);
        chk_status("c4", 1'b1, 1'b0, 1'b0, 16'd2);

        // Case 5: reset after six payload bytes, then a full reload
        pulse_start();
        sb.push_back({32'h0000_0000, 32'hE3A0_1005});
        frame = '{8'h02, 8'h00, 8'h05, 8'h10, 8'hA0, 8'hE3, 8'h00, 8'h00};
        send_frame(0);
        chk("c5_cpu_rst_mid", {31'd0, cpu_rst}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("c5_cpu_rst_after", {31'd0, cpu_rst}, 32'd1);
        chk("c5_busy_after", {31'd0, busy}, 32'd0);
        chk("c5_words_after", {16'd0, words_loaded}, 32'd0);
        chk("c5_rx_ready_after", {31'd0, rx_ready}, 32'd1);
        push_case1();
        frame = '{8'h02, 8'h00, 8'h05, 8'h10, 8'hA0, 8'hE3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h56};
        send_frame(0);
        chk_status("c5", 1'b1, 1'b0, 1'b0, 16'd2);

        // Start outside DONE/ERR is ignored
        // Case 6: restart with a one-word image
        pulse_start();
        chk("c6_cpu_rst_reassert", {31'd0, cpu_rst}, 32'd1);
        sb.push_back({32'h0000_0000, 32'h1234_5678});
        frame = '{8'h01, 8'h00, 8'h78};
        send_frame(0);
        pulse_start();
        chk("c6_start_ignored_busy", {31'd0, busy}, 32'd1);
        frame = '{8'h56, 8'h34, 8'h12, 8'h08};
        send_frame(0);
        chk_status("c6", 1'b1, 1'b0, 1'b0, 16'd1);

        repeat (3) @(negedge clk);
        chk("pending_writes", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
